usart_rx: RTL and testbench

UART/USART receiver, the counterpart of the team's USART transmitter.
- Deserialises 8N1 frames from the `rx` pin using mid-bit sampling.
- Buffers received bytes in an internal FIFO.
- Presents bytes to the fabric over a valid/ready handshake.
- Sits between the board-level RX pin and the host-side logic that consumes bytes.

---
 rtl/usart_pkg.sv | 23 ++
 rtl/usart_fifo.sv | 52 +++++
 rtl/usart_rx.sv | 161 ++++++++++++++++
 tb/tb_usart_rx.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/usart_pkg.sv
// Shared definitions for the USART receiver and transmitter: FSM encoding,
// default configuration and the baud divider helper.
package usart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } rx_state_t;

  localparam int DEF_CLK_FREQ   = 100000000;
  localparam int DEF_BAUD_RATE  = 115200;
  localparam int DEF_DATA_BIT   = 8;
  localparam int DEF_NUM_OF_BUFS = 16;

  function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/usart_fifo.sv
// First-word-fall-through FIFO; dout shows the head entry and reads as zero
// while empty. A push into a full FIFO is taken only alongside a pop.
module usart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/usart_rx.sv
// USART receiver: mid-bit sampling of 8N1 frames into a FWFT byte FIFO.
// Define USART_RX_PARITY_EN to add a parity bit, PARITY_ODD and parity_err.
module usart_rx
  import usart_pkg::*;
#(
  parameter int CLK_FREQ    = DEF_CLK_FREQ,
  parameter int BAUD_RATE   = DEF_BAUD_RATE,
  parameter int DATA_BIT    = DEF_DATA_BIT,
  parameter int NUM_OF_BUFS = DEF_NUM_OF_BUFS
`ifdef USART_RX_PARITY_EN
  ,
  parameter bit PARITY_ODD  = 1'b0
`endif
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rx,
  output logic [DATA_BIT-1:0]           rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          frame_err,
  output logic                          overrun,
  output logic [$clog2(NUM_OF_BUFS):0]  fifo_count,
  output logic                          busy
`ifdef USART_RX_PARITY_EN
  ,
  output logic                          parity_err
`endif
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W        = $clog2(DATA_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(HALF_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BIT - 1);

  rx_state_t           state;
  rx_state_t           state_n;
  logic                rx_meta;
  logic                rx_s;
  logic [CNT_W-1:0]    clk_cnt;
  logic [BIT_W-1:0]    bit_idx;
  logic [DATA_BIT-1:0] shreg;
  logic                cnt_last;
  logic                cnt_half;
  logic                fifo_push;
  logic                fifo_pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic                ferr_d;
  logic                ovr_d;
`ifdef USART_RX_PARITY_EN
  logic                parity_bit;
  logic                perr_d;
`endif

  assign cnt_last = (clk_cnt == CNT_LAST);
  assign cnt_half = (clk_cnt == CNT_HALF);
  assign fifo_pop = rx_valid && rx_ready;
  assign rx_valid = !fifo_empty;

  // Both flops reset high so a reset never looks like a start edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) {rx_meta, rx_s} <= 2'b11;
    else        {rx_meta, rx_s} <= {rx, rx_meta};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:      if (!rx_s) state_n = START;
      START:     if (cnt_half) state_n = rx_s ? IDLE : DATA;
`ifdef USART_RX_PARITY_EN
      DATA:      if (cnt_last && bit_idx == BIT_LAST) state_n = PARITY;
`else
      DATA:      if (cnt_last && bit_idx == BIT_LAST) state_n = STOP;
`endif
      PARITY:    if (cnt_last) state_n = STOP;
      STOP:      if (cnt_last) state_n = rx_s ? IDLE : WAIT_IDLE;
      WAIT_IDLE: if (rx_s) state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  // Stop-bit verdict: a simultaneous pop frees a slot, so only a full FIFO
  // with no pop counts as an overrun.
  always_comb begin
    fifo_push = 1'b0;
    ferr_d    = 1'b0;
    ovr_d     = 1'b0;
    busy      = (state != IDLE);
`ifdef USART_RX_PARITY_EN
    perr_d    = 1'b0;
`endif
    if (state == STOP && cnt_last) begin
      if (!rx_s)
        ferr_d = 1'b1;
`ifdef USART_RX_PARITY_EN
      else if ((^shreg ^ parity_bit) != PARITY_ODD)
        perr_d = 1'b1;
`endif
      else if (fifo_full && !fifo_pop)
        ovr_d = 1'b1;
      else
        fifo_push = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_cnt   <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= ferr_d;
      overrun   <= ovr_d;
      if (state_n != state || state == IDLE || cnt_last) clk_cnt <= '0;
      else                                                clk_cnt <= clk_cnt + CNT_W'(1);
      if (state != DATA)  bit_idx <= '0;
      else if (cnt_last)  bit_idx <= bit_idx + BIT_W'(1);
      if (state == DATA && cnt_last) shreg <= {rx_s, shreg[DATA_BIT-1:1]};
    end
  end

`ifdef USART_RX_PARITY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      parity_bit <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      parity_err <= perr_d;
      if (state == PARITY && cnt_last) parity_bit <= rx_s;
    end
  end
`endif

  usart_fifo #(
    .WIDTH (DATA_BIT),
    .DEPTH (NUM_OF_BUFS)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .din   (shreg),
    .pop   (fifo_pop),
    .dout  (rx_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_usart_rx.sv
// Self-checking bench for usart_rx at 16 clocks per bit with a 4-deep FIFO;
// a scoreboard queue holds the bytes expected at the handshake.
module tb_usart_rx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic [2:0] fifo_count;
  logic       busy;
`ifdef USART_RX_PARITY_EN
  logic       parity_err;
`endif

  int         tests_run = 0;
  int         tests_failed = 0;
  int         ferr_cnt = 0;
  int         ovr_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_b;

  usart_rx #(
    .CLK_FREQ    (1600),
    .BAUD_RATE   (100),
    .DATA_BIT    (8),
    .NUM_OF_BUFS (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .fifo_count (fifo_count),
    .busy       (busy)
`ifdef USART_RX_PARITY_EN
    ,
    .parity_err (parity_err)
`endif
  );

  always #5 clk = ~clk;

  // Scoreboard side: every accepted handshake must match the oldest expected byte.
  always @(negedge clk) begin
    #1;
    if (frame_err) ferr_cnt++;
    if (overrun)   ovr_cnt++;
    if (frame_err && overrun) begin
      tests_run++; tests_failed++;
      $display("[TB] FAIL flags_together frame_err=%b overrun=%b, want not both", frame_err, overrun);
    end
    if (reset && rx_valid && rx_ready) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("[TB] FAIL unexpected_byte got %h, want nothing", rx_data);
      end else begin
        exp_b = exp_q.pop_front();
        if (rx_data !== exp_b) begin
          tests_failed++;
          $display("[TB] FAIL rx_data got %h, want %h", rx_data, exp_b);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  task automatic send_bit(input logic v);
    rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop_bit);
  endtask

  task automatic test_reset;
    reset = 1'b0; rx = 1'b1; rx_ready = 1'b1;
    repeat (3) @(negedge clk);
    tests_run += 6;
    if (rx_data !== 8'h00)   begin tests_failed++; $display("[TB] FAIL reset_rx_data got %h, want 00", rx_data); end
    if (rx_valid !== 1'b0)   begin tests_failed++; $display("[TB] FAIL reset_rx_valid got %b, want 0", rx_valid); end
    if (frame_err !== 1'b0)  begin tests_failed++; $display("[TB] FAIL reset_frame_err got %b, want 0", frame_err); end
    if (overrun !== 1'b0)    begin tests_failed++; $display("[TB] FAIL reset_overrun got %b, want 0", overrun); end
    if (fifo_count !== 3'd0) begin tests_failed++; $display("[TB] FAIL reset_fifo_count got %0d, want 0", fifo_count); end
    if (busy !== 1'b0)       begin tests_failed++; $display("[TB] FAIL reset_busy got %b, want 0", busy); end
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single;
    int cyc;
    logic [7:0] got_data;
    logic [2:0] got_cnt;
    logic       valid_after;
    logic [2:0] cnt_after;
    cyc = 0;
    exp_q.push_back(8'hA5);
    fork
      send_frame(8'hA5, 1'b1);
      begin
        while (rx_valid !== 1'b1 && cyc < 400) begin @(negedge clk); cyc++; end
        got_data = rx_data; got_cnt = fifo_count;
        @(negedge clk);
        valid_after = rx_valid; cnt_after = fifo_count;
      end
    join
    repeat (2) @(negedge clk);
    tests_run += 6;
    if (cyc != 155)            begin tests_failed++; $display("[TB] FAIL single_latency got %0d, want 155", cyc); end
    if (got_data !== 8'hA5)    begin tests_failed++; $display("[TB] FAIL single_data got %h, want a5", got_data); end
    if (got_cnt !== 3'd1)      begin tests_failed++; $display("[TB] FAIL single_count got %0d, want 1", got_cnt); end
    if (valid_after !== 1'b0)  begin tests_failed++; $display("[TB] FAIL single_popped got %b, want 0", valid_after); end
    if (cnt_after !== 3'd0)    begin tests_failed++; $display("[TB] FAIL single_count_after got %0d, want 0", cnt_after); end
    if (exp_q.size() != 0)     begin tests_failed++; $display("[TB] FAIL single_pending got %0d, want 0", exp_q.size()); end
  endtask

  task automatic test_overrun;
    int cyc;
    ferr_cnt = 0; ovr_cnt = 0;
    rx_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) exp_q.push_back(8'(i));
      send_frame(8'(i), 1'b1);
    end
    repeat (2) @(negedge clk);
    tests_run += 3;
    if (fifo_count !== 3'd4) begin tests_failed++; $display("[TB] FAIL overrun_count got %0d, want 4", fifo_count); end
    if (ovr_cnt != 1)        begin tests_failed++; $display("[TB] FAIL overrun_pulses got %0d, want 1", ovr_cnt); end
    if (ferr_cnt != 0)       begin tests_failed++; $display("[TB] FAIL overrun_ferr got %0d, want 0", ferr_cnt); end
    rx_ready = 1'b1;
    cyc = 0;
    while (fifo_count !== 3'd0 && cyc < 20) begin @(negedge clk); cyc++; end
    repeat (2) @(negedge clk);
    tests_run += 2;
    if (fifo_count !== 3'd0) begin tests_failed++; $display("[TB] FAIL overrun_drain got %0d, want 0", fifo_count); end
    if (exp_q.size() != 0)   begin tests_failed++; $display("[TB] FAIL overrun_pending got %0d, want 0", exp_q.size()); end
  endtask

  task automatic test_glitch;
    ferr_cnt = 0;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    tests_run++;
    if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL glitch_busy_start got %b, want 1", busy); end
    @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    tests_run += 4;
    if (busy !== 1'b0)       begin tests_failed++; $display("[TB] FAIL glitch_busy got %b, want 0", busy); end
    if (rx_valid !== 1'b0)   begin tests_failed++; $display("[TB] FAIL glitch_valid got %b, want 0", rx_valid); end
    if (fifo_count !== 3'd0) begin tests_failed++; $display("[TB] FAIL glitch_count got %0d, want 0", fifo_count); end
    if (ferr_cnt != 0)       begin tests_failed++; $display("[TB] FAIL glitch_ferr got %0d, want 0", ferr_cnt); end
  endtask

  task automatic test_frame_error;
    ferr_cnt = 0; ovr_cnt = 0;
    send_frame(8'h3C, 1'b0);
    repeat (3 * CPB) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    tests_run += 4;
    if (ferr_cnt != 1)       begin tests_failed++; $display("[TB] FAIL ferr_pulses got %0d, want 1", ferr_cnt); end
    if (fifo_count !== 3'd0) begin tests_failed++; $display("[TB] FAIL ferr_count got %0d, want 0", fifo_count); end
    if (busy !== 1'b0)       begin tests_failed++; $display("[TB] FAIL ferr_busy got %b, want 0", busy); end
    if (ovr_cnt != 0)        begin tests_failed++; $display("[TB] FAIL ferr_overrun got %0d, want 0", ovr_cnt); end
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1);
    repeat (4) @(negedge clk);
    tests_run += 2;
    if (exp_q.size() != 0)   begin tests_failed++; $display("[TB] FAIL ferr_next_pending got %0d, want 0", exp_q.size()); end
    if (ferr_cnt != 1)       begin tests_failed++; $display("[TB] FAIL ferr_after_good got %0d, want 1", ferr_cnt); end
  endtask

  task automatic test_full_push_pop;
    int cyc;
    logic [2:0] cnt_at_push;
    ovr_cnt = 0;
    rx_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(8'h10 + 8'(i));
      send_frame(8'h10 + 8'(i), 1'b1);
    end
    exp_q.push_back(8'h55);
    fork
      send_frame(8'h55, 1'b1);
      begin
        repeat (154) @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        cnt_at_push = fifo_count;
      end
    join
    repeat (2) @(negedge clk);
    tests_run += 3;
    if (cnt_at_push !== 3'd4) begin tests_failed++; $display("[TB] FAIL full_pp_count got %0d, want 4", cnt_at_push); end
    if (ovr_cnt != 0)         begin tests_failed++; $display("[TB] FAIL full_pp_overrun got %0d, want 0", ovr_cnt); end
    if (exp_q.size() != 4)    begin tests_failed++; $display("[TB] FAIL full_pp_popped got %0d pending, want 4", exp_q.size()); end
    rx_ready = 1'b1;
    cyc = 0;
    while (fifo_count !== 3'd0 && cyc < 20) begin @(negedge clk); cyc++; end
    repeat (2) @(negedge clk);
    tests_run++;
    if (exp_q.size() != 0) begin tests_failed++; $display("[TB] FAIL full_pp_pending got %0d, want 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] b;
    b = 8'h5A;
    rx_ready = 1'b0;
    send_frame(8'h99, 1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(b[i]);
    rx = b[4];
    repeat (3) @(negedge clk);
    tests_run += 2;
    if (busy !== 1'b1)       begin tests_failed++; $display("[TB] FAIL mid_busy got %b, want 1", busy); end
    if (fifo_count !== 3'd1) begin tests_failed++; $display("[TB] FAIL mid_count got %0d, want 1", fifo_count); end
    reset = 1'b0;
    #1;
    tests_run += 5;
    if (busy !== 1'b0)       begin tests_failed++; $display("[TB] FAIL rst_mid_busy got %b, want 0", busy); end
    if (rx_valid !== 1'b0)   begin tests_failed++; $display("[TB] FAIL rst_mid_valid got %b, want 0", rx_valid); end
    if (fifo_count !== 3'd0) begin tests_failed++; $display("[TB] FAIL rst_mid_count got %0d, want 0", fifo_count); end
    if (rx_data !== 8'h00)   begin tests_failed++; $display("[TB] FAIL rst_mid_data got %h, want 00", rx_data); end
    if (frame_err !== 1'b0 || overrun !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL rst_mid_flags got %b%b, want 00", frame_err, overrun);
    end
    rx = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    rx_ready = 1'b1;
    @(negedge clk);
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1);
    repeat (4) @(negedge clk);
    tests_run++;
    if (exp_q.size() != 0) begin tests_failed++; $display("[TB] FAIL rst_next_pending got %0d, want 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overrun();
    test_glitch();
    test_frame_error();
    test_full_push_pop();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
